// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS memory / write-back pipeline slice.
//   DATA_W        : datapath width (32)
//   REG_W         : register-number width (5)
//   DEPTH_DEFAULT : default number of data-memory words (256)
//   mem_wb_t      : contents of the MEM/WB pipeline register
//   is_misaligned : word-access alignment check
package mips_pkg;

    localparam int DATA_W        = 32;
    localparam int REG_W         = 5;
    localparam int DEPTH_DEFAULT = 256;

    typedef struct packed {
        logic              memto_reg;
        logic [DATA_W-1:0] readdata;
        logic [DATA_W-1:0] alu_out;
        logic              reg_write;
        logic [REG_W-1:0]  write_reg;
        logic              misaligned;
    } mem_wb_t;

    // Only memory accesses can fault; an R-type with odd low bits is fine.
    function automatic logic is_misaligned(input logic       mem_read,
                                           input logic       mem_write,
                                           input logic [1:0] addr_lsb);
        return (mem_read || mem_write) && (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bus between the MEM stage and the MEM/WB register.
//   master : the pipeline driving MEM* control/data plus stall/flush,
//            receiving the registered WB* fields
//   slave  : mem_wb_stage itself
interface mem_wb_stage_if;
    import mips_pkg::*;

    logic              MEMmemRead;
    logic              MEMmemWrite;
    logic              MEMmemtoReg;
    logic              MEMregWrite;
    logic [DATA_W-1:0] MEMaluOut;
    logic [DATA_W-1:0] MEMwriteData;
    logic [REG_W-1:0]  MEMwriteReg;
    logic              stall;
    logic              flush;

    logic              WBmemtoReg;
    logic [DATA_W-1:0] WBreaddata;
    logic [DATA_W-1:0] WBaluOut;
    logic              WBregWrite;
    logic [REG_W-1:0]  WBwriteReg;
    logic              WBmisaligned;

    modport master (
        output MEMmemRead, MEMmemWrite, MEMmemtoReg, MEMregWrite,
               MEMaluOut, MEMwriteData, MEMwriteReg, stall, flush,
        input  WBmemtoReg, WBreaddata, WBaluOut, WBregWrite,
               WBwriteReg, WBmisaligned
    );

    modport slave (
        input  MEMmemRead, MEMmemWrite, MEMmemtoReg, MEMregWrite,
               MEMaluOut, MEMwriteData, MEMwriteReg, stall, flush,
        output WBmemtoReg, WBreaddata, WBaluOut, WBregWrite,
               WBwriteReg, WBmisaligned
    );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: one synchronous write port, one asynchronous
// read port sharing the same word index.
//   clk   : write clock
//   we    : write enable (already gated by the caller)
//   addr  : word index
//   wdata : store data
//   rdata : combinational read of mem[addr] (pre-write contents this cycle)
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are undefined until written,
    // which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read gives read-before-write when a load and store meet.
    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage memory access plus the MEM/WB pipeline register.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset of the pipeline register only
//   bus   : mem_wb_stage_if.slave -- MEM* inputs, stall/flush, WB* outputs
// Word index is MEMaluOut[log2(DEPTH)+1:2]; higher address bits wrap.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     index;
    logic              misaligned;
    logic              store_en;
    logic [DATA_W-1:0] mem_rdata;
    mem_wb_t           wb_next;
    mem_wb_t           wb_q;

    assign index      = bus.MEMaluOut[AW+1:2];
    assign misaligned = is_misaligned(bus.MEMmemRead, bus.MEMmemWrite,
                                      bus.MEMaluOut[1:0]);

    // Any condition that stops the register from advancing also kills the store.
    assign store_en = bus.MEMmemWrite && !misaligned && !bus.stall
                      && !bus.flush && !reset;

    data_mem #(.DEPTH(DEPTH)) u_data_mem (
        .clk   (clk),
        .we    (store_en),
        .addr  (index),
        .wdata (bus.MEMwriteData),
        .rdata (mem_rdata)
    );

    // NOTE: every field gets a value on every path so no latch is inferred.
    always_comb begin
        wb_next            = '0;
        wb_next.memto_reg  = bus.MEMmemtoReg;
        wb_next.alu_out    = bus.MEMaluOut;
        wb_next.write_reg  = bus.MEMwriteReg;
        wb_next.misaligned = misaligned;
        wb_next.reg_write  = bus.MEMregWrite && !misaligned;
        if (bus.MEMmemRead && !misaligned) begin
            wb_next.readdata = mem_rdata;
        end
    end

    // Priority: reset, then flush (bubble), then stall (hold).
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else if (bus.flush) begin
            wb_q <= '0;
        end else if (!bus.stall) begin
            wb_q <= wb_next;
        end
    end

    assign bus.WBmemtoReg   = wb_q.memto_reg;
    assign bus.WBreaddata   = wb_q.readdata;
    assign bus.WBaluOut     = wb_q.alu_out;
    assign bus.WBregWrite   = wb_q.reg_write;
    assign bus.WBwriteReg   = wb_q.write_reg;
    assign bus.WBmisaligned = wb_q.misaligned;

endmodule
